// File: rtl/wb_merge_unit.sv
// wb_merge_unit: merges the ALU and memory writeback lanes onto the single
// register-file write port. Entries leave in program order, using a small FIFO
// when both lanes write in the same cycle or when a backlog has built up.
module wb_merge_unit #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_wr_en,
    input  logic [AW-1:0] alu_wr_addr,
    input  logic [DW-1:0] alu_wr_data,
    input  logic          mem_wr_en,
    input  logic [AW-1:0] mem_wr_addr,
    input  logic [DW-1:0] mem_wr_data,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    output logic          stall_out,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] fifoAddr_q [DEPTH];
    logic [DW-1:0] fifoData_q [DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] wrIdxMem;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          rfWrEn_q, rfWrEn_d;
    logic [AW-1:0] rfWrAddr_q, rfWrAddr_d;
    logic [DW-1:0] rfWrData_q, rfWrData_d;

    logic          aluLive, memLive, fifoEmpty, deq;
    logic          wantAlu, wantMem, accAlu, accMem;
    logic [CW:0]   space;

    // Lane filtering and enqueue decisions; a dequeue frees its slot this cycle
    // and, when room is short, the memory entry is the one dropped.
    always_comb begin
        aluLive   = alu_wr_en && (alu_wr_addr != '0);
        memLive   = mem_wr_en && (mem_wr_addr != '0);
        fifoEmpty = (count_q == '0);
        deq       = !fifoEmpty;
        wantAlu   = !fifoEmpty && aluLive;
        wantMem   = memLive && (!fifoEmpty || aluLive);
        space     = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, deq};
        accAlu    = wantAlu && (space != '0);
        accMem    = wantMem && (space > {{CW{1'b0}}, accAlu});
        wrIdxMem  = wrPtr_q + {{(PW-1){1'b0}}, accAlu};
        wrPtr_d   = wrPtr_q + {{(PW-1){1'b0}}, accAlu} + {{(PW-1){1'b0}}, accMem};
        rdPtr_d   = rdPtr_q + {{(PW-1){1'b0}}, deq};
        count_d   = count_q + {{(CW-1){1'b0}}, accAlu} + {{(CW-1){1'b0}}, accMem}
                    - {{(CW-1){1'b0}}, deq};
        overflow_d = overflow_q || (wantAlu && !accAlu) || (wantMem && !accMem);
    end

    // Output source selection: queued backlog first, then the bypass lanes.
    always_comb begin
        rfWrEn_d   = 1'b0;
        rfWrAddr_d = rfWrAddr_q;
        rfWrData_d = rfWrData_q;
        if (!fifoEmpty) begin
            rfWrEn_d   = 1'b1;
            rfWrAddr_d = fifoAddr_q[rdPtr_q];
            rfWrData_d = fifoData_q[rdPtr_q];
        end else if (aluLive) begin
            rfWrEn_d   = 1'b1;
            rfWrAddr_d = alu_wr_addr;
            rfWrData_d = alu_wr_data;
        end else if (memLive) begin
            rfWrEn_d   = 1'b1;
            rfWrAddr_d = mem_wr_addr;
            rfWrData_d = mem_wr_data;
        end
    end

    // Control state and output register; reset discards any queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rfWrEn_q   <= 1'b0;
            rfWrAddr_q <= '0;
            rfWrData_q <= '0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rfWrEn_q   <= rfWrEn_d;
            rfWrAddr_q <= rfWrAddr_d;
            rfWrData_q <= rfWrData_d;
        end
    end

    // FIFO storage needs no reset since validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (accAlu) begin
            fifoAddr_q[wrPtr_q] <= alu_wr_addr;
            fifoData_q[wrPtr_q] <= alu_wr_data;
        end
        if (accMem) begin
            fifoAddr_q[wrIdxMem] <= mem_wr_addr;
            fifoData_q[wrIdxMem] <= mem_wr_data;
        end
    end

    assign rf_wr_en   = rfWrEn_q;
    assign rf_wr_addr = rfWrAddr_q;
    assign rf_wr_data = rfWrData_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign stall_out  = (count_q >= CW'(DEPTH - 2));

endmodule

// File: tb/tb_wb_merge_unit.sv
// tb_wb_merge_unit: directed writeback vectors with a program-order scoreboard
// for the register-file port plus direct checks of count, stall and overflow.
module tb_wb_merge_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          aluWrEn, memWrEn;
    logic [AW-1:0] aluWrAddr, memWrAddr;
    logic [DW-1:0] aluWrData, memWrData;
    logic          rfWrEn;
    logic [AW-1:0] rfWrAddr;
    logic [DW-1:0] rfWrData;
    logic          stallOut;
    logic [CW-1:0] fifoCount;
    logic          overflowFlag;

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] expQ [$];

    wb_merge_unit #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_wr_en   (aluWrEn),
        .alu_wr_addr (aluWrAddr),
        .alu_wr_data (aluWrData),
        .mem_wr_en   (memWrEn),
        .mem_wr_addr (memWrAddr),
        .mem_wr_data (memWrData),
        .rf_wr_en    (rfWrEn),
        .rf_wr_addr  (rfWrAddr),
        .rf_wr_data  (rfWrData),
        .stall_out   (stallOut),
        .fifo_count  (fifoCount),
        .overflow    (overflowFlag)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every register-file write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && rfWrEn) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0h, none expected",
                         rfWrAddr, rfWrData);
            end else begin
                logic [AW+DW-1:0] exp;
                exp = expQ.pop_front();
                if ({rfWrAddr, rfWrData} !== exp) begin
                    errors++;
                    $display("[TB] FAIL rf_write: got addr %0d data %0h, expected addr %0d data %0h",
                             rfWrAddr, rfWrData, exp[AW+DW-1:DW], exp[DW-1:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of lane inputs; pushA/pushM say which entries must reach the RF.
    task automatic applyStimulus(input logic aEn, input logic [AW-1:0] aAddr,
                                 input logic [DW-1:0] aData, input logic mEn,
                                 input logic [AW-1:0] mAddr, input logic [DW-1:0] mData,
                                 input logic pushA, input logic pushM);
        aluWrEn = aEn; aluWrAddr = aAddr; aluWrData = aData;
        memWrEn = mEn; memWrAddr = mAddr; memWrData = mData;
        if (pushA) expQ.push_back({aAddr, aData});
        if (pushM) expQ.push_back({mAddr, mData});
        @(posedge clk); #1;
        aluWrEn = 1'b0; aluWrAddr = '0; aluWrData = '0;
        memWrEn = 1'b0; memWrAddr = '0; memWrData = '0;
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
    endtask

    // Wait, bounded, until every expected write has been observed.
    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 20) begin
            idleCycle();
            n++;
        end
        checkOutput(name, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        aluWrEn = 1'b0; aluWrAddr = '0; aluWrData = '0;
        memWrEn = 1'b0; memWrAddr = '0; memWrData = '0;
        #12;
        checkOutput("reset_rf_en",    64'(rfWrEn),       64'd0);
        checkOutput("reset_rf_addr",  64'(rfWrAddr),     64'd0);
        checkOutput("reset_rf_data",  64'(rfWrData),     64'd0);
        checkOutput("reset_count",    64'(fifoCount),    64'd0);
        checkOutput("reset_stall",    64'(stallOut),     64'd0);
        checkOutput("reset_overflow", 64'(overflowFlag), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        idleCycle();

        $display("[TB] single ALU write");
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0);
        checkOutput("single_en",   64'(rfWrEn),   64'd1);
        checkOutput("single_addr", 64'(rfWrAddr), 64'd5);
        checkOutput("single_data", 64'(rfWrData), 64'hDEADBEEF);
        idleCycle();
        checkOutput("single_en_after", 64'(rfWrEn), 64'd0);

        $display("[TB] dual write");
        applyStimulus(1, 3, 32'h11, 1, 4, 32'h22, 1, 1);
        checkOutput("dual_addr0",  64'(rfWrAddr),  64'd3);
        checkOutput("dual_count0", 64'(fifoCount), 64'd1);
        idleCycle();
        checkOutput("dual_addr1",  64'(rfWrAddr),  64'd4);
        checkOutput("dual_data1",  64'(rfWrData),  64'h22);
        checkOutput("dual_count1", 64'(fifoCount), 64'd0);
        idleCycle();
        checkOutput("dual_en_after", 64'(rfWrEn), 64'd0);

        $display("[TB] zero-register filter");
        applyStimulus(1, 0, 32'hBAD, 1, 7, 32'h77, 0, 1);
        checkOutput("zero_en",    64'(rfWrEn),    64'd1);
        checkOutput("zero_addr",  64'(rfWrAddr),  64'd7);
        checkOutput("zero_count", 64'(fifoCount), 64'd0);
        applyStimulus(1, 0, 32'h1, 1, 0, 32'h2, 0, 0);
        checkOutput("zero_both_en", 64'(rfWrEn), 64'd0);
        checkOutput("zero_hold_addr", 64'(rfWrAddr), 64'd7);
        applyStimulus(0, 9, 32'h99, 1, 6, 32'h66, 0, 1);
        checkOutput("mem_only_addr", 64'(rfWrAddr), 64'd6);

        $display("[TB] fill and stall");
        applyStimulus(1, 1, 32'h1, 1, 2, 32'h2, 1, 1);
        checkOutput("fill_count1", 64'(fifoCount), 64'd1);
        checkOutput("fill_stall1", 64'(stallOut),  64'd0);
        applyStimulus(1, 3, 32'h3, 1, 4, 32'h4, 1, 1);
        checkOutput("fill_count2", 64'(fifoCount), 64'd2);
        checkOutput("fill_stall2", 64'(stallOut),  64'd1);
        applyStimulus(1, 5, 32'h5, 1, 6, 32'h6, 1, 1);
        checkOutput("fill_count3", 64'(fifoCount), 64'd3);
        checkOutput("fill_stall3", 64'(stallOut),  64'd1);
        waitDrain("fill_drain");
        checkOutput("fill_count_end", 64'(fifoCount), 64'd0);
        checkOutput("fill_stall_end", 64'(stallOut),  64'd0);

        $display("[TB] overflow");
        applyStimulus(1, 8,  32'h80, 1, 9,  32'h90, 1, 1);
        applyStimulus(1, 10, 32'hA0, 1, 11, 32'hB0, 1, 1);
        applyStimulus(1, 12, 32'hC0, 1, 13, 32'hD0, 1, 1);
        applyStimulus(1, 14, 32'hE0, 1, 15, 32'hF0, 1, 1);
        checkOutput("ovf_count4",   64'(fifoCount),    64'd4);
        checkOutput("ovf_before",   64'(overflowFlag), 64'd0);
        applyStimulus(1, 16, 32'h100, 1, 17, 32'h110, 1, 0);
        checkOutput("ovf_count_sat", 64'(fifoCount),    64'd4);
        checkOutput("ovf_set",       64'(overflowFlag), 64'd1);
        waitDrain("ovf_drain");
        checkOutput("ovf_sticky",    64'(overflowFlag), 64'd1);

        $display("[TB] reset mid-drain");
        applyStimulus(1, 20, 32'h200, 1, 21, 32'h210, 1, 1);
        applyStimulus(1, 22, 32'h220, 1, 23, 32'h230, 1, 1);
        applyStimulus(1, 24, 32'h240, 1, 25, 32'h250, 1, 1);
        checkOutput("rst_pre_count", 64'(fifoCount), 64'd3);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_rf_en",    64'(rfWrEn),       64'd0);
        checkOutput("rst_rf_addr",  64'(rfWrAddr),     64'd0);
        checkOutput("rst_rf_data",  64'(rfWrData),     64'd0);
        checkOutput("rst_count",    64'(fifoCount),    64'd0);
        checkOutput("rst_overflow", 64'(overflowFlag), 64'd0);
        checkOutput("rst_stall",    64'(stallOut),     64'd0);
        expQ.delete();
        @(negedge clk); rst_n = 1'b1;
        idleCycle();
        checkOutput("rst_no_stale", 64'(rfWrEn), 64'd0);
        applyStimulus(1, 2, 32'h1234, 0, 0, 0, 1, 0);
        checkOutput("post_rst_addr", 64'(rfWrAddr), 64'd2);
        checkOutput("post_rst_data", 64'(rfWrData), 64'h1234);
        waitDrain("post_rst_drain");
        idleCycle();
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_merge_unit.md
Name: wb_merge_unit

Overview:
- Writeback merge stage directly downstream of the ALU subpipeline and the memory subpipeline.
- Takes each lane's writeback triple (write enable, destination register address, data) and serialises them onto the single register-file write port.
- Program order is preserved through a small FIFO.
- Raises a stall to the issue logic before the FIFO can overflow.

Parameters:
- DW, 32, writeback data width
- AW, 5, register address width
- DEPTH, 4, FIFO entries (power of two, >= 4)
- CW, 3, width of the FIFO occupancy count (log2(DEPTH)+1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_wr_en  in  1  ALU lane writeback valid (ALU pipe RegWr)
- alu_wr_addr  in  AW  ALU lane destination (ALU pipe regmuxout[4:0])
- alu_wr_data  in  DW  ALU lane result (ALU pipe busW)
- mem_wr_en  in  1  memory lane writeback valid
- mem_wr_addr  in  AW  memory lane destination
- mem_wr_data  in  DW  memory lane load/ALU result
- rf_wr_en  out  1  register-file write enable (registered)
- rf_wr_addr  out  AW  register-file write address (registered)
- rf_wr_data  out  DW  register-file write data (registered)
- stall_out  out  1  issue stall request (combinational from count)
- fifo_count  out  CW  current FIFO occupancy
- overflow  out  1  sticky error flag, an entry was dropped

Behaviour:
- Reset, asynchronous on rst_n low: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, fifo_count=0, overflow=0, read/write pointers=0. Takes effect immediately, including mid-drain; queued entries are discarded.
- Input filter: a lane is live only if wr_en=1 and wr_addr != 0. Writes to $0 are discarded and never enqueued or output.
- Same-cycle ordering: the ALU entry is older than the memory entry.
- Each posedge, the output register is loaded from exactly one source, by priority:
  1. FIFO head, if count > 0.
  2. Live ALU lane, if FIFO empty.
  3. Live memory lane, if FIFO empty and ALU not live.
  4. Nothing: rf_wr_en=0; addr/data hold their previous values.
- Enqueue rules:
  - FIFO non-empty: all live lanes enqueue, ALU first, then memory.
  - FIFO empty and both lanes live: ALU goes to the output, memory enqueues.
  - FIFO empty and one lane live: that lane goes to the output; nothing enqueues.
- Latency: 1 cycle from input to rf_wr_* when bypassing the FIFO. Queued entries are output strictly in arrival order, one per cycle.
- Count update: count_next = count - dequeue + enqueues. Up to 2 enqueues and 1 dequeue per cycle.
- Capacity: a dequeue frees its slot in the same cycle.
  - Entries that would exceed DEPTH are dropped, memory entry first.
  - A drop sets overflow=1; it stays set until reset.
  - Count saturates at DEPTH.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer compare.
- stall_out = 1 when count >= DEPTH-2. This guarantees one more cycle of dual enqueue in flight cannot overflow. stall_out is 0 at reset.
- No data forwarding or address coalescing. Two writes to the same register appear as two sequential rf writes in order, so the later value wins.

Test Plan:
- Reset: assert rst_n=0 mid-run with 3 queued entries -> all outputs 0 and fifo_count=0 immediately; after release, the first new write appears normally.
- Single ALU write: alu_wr_en=1, addr=5, data=0xDEADBEEF for 1 cycle -> next cycle rf_wr_en=1, addr=5, data=0xDEADBEEF; the cycle after, rf_wr_en=0.
- Dual write: ALU (r3, 0x11) and MEM (r4, 0x22) in the same cycle -> cycle+1 r3/0x11, cycle+2 r4/0x22, fifo_count 1 then 0.
- $0 filter: ALU addr=0 with MEM (r7, 0x77) in the same cycle -> only r7/0x77 is written, at cycle+1; fifo_count stays 0.
- Fill and stall: 3 consecutive dual writes -> fifo_count 1, 2, 3; stall_out rises when count reaches 2; drain order matches issue order exactly.
- Overflow: force dual writes with stall ignored until count=DEPTH -> next dual write drops the MEM entry, overflow=1 and stays set; the remaining entries drain in order.
